// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS32 core.
// Tracks EX/MEM/WB in a shadow scoreboard and drives stalls, flushes, bubbles and forwarding selects.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       id_dest,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             id_bypass_a,
   output logic             id_bypass_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned RW = 5;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic          v;
      logic [RW-1:0] dest;
      logic          rw;
      logic          mr;
   } slot_t;

   // A load in WB forwards exactly like an ALU result, so WB keeps no mem_read bit.
   typedef struct packed {
      logic          v;
      logic [RW-1:0] dest;
      logic          rw;
   } wb_slot_t;

   typedef struct packed {
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic          urs;
      logic          urt;
   } ex_src_t;

   slot_t            ex_q, ex_d, mem_q, mem_d;
   wb_slot_t         wb_q, wb_d;
   ex_src_t          exs_q, exs_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic load_use;
   logic bubble;
   logic mem_load_hit;

   function automatic logic slot_writes(slot_t s, logic [RW-1:0] r);
      return s.v && s.rw && (s.dest == r) && (r != 5'd0);
   endfunction

   function automatic logic wb_writes(wb_slot_t s, logic [RW-1:0] r);
      return s.v && s.rw && (s.dest == r) && (r != 5'd0);
   endfunction

   // Load in EX whose destination the ID instruction reads.
   assign load_use = ex_q.v && ex_q.mr && ex_q.rw && (ex_q.dest != 5'd0) && id_valid &&
                     ((id_uses_rs && (id_rs == ex_q.dest)) ||
                      (id_uses_rt && (id_rt == ex_q.dest)));

   assign bubble = ex_redirect || load_use;

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (reset) begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
      end else if (mem_busy) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (ex_redirect) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   // Scoreboard advance and event counting; everything holds while memory is busy.
   always_comb begin
      ex_d    = ex_q;
      mem_d   = mem_q;
      wb_d    = wb_q;
      exs_d   = exs_q;
      stall_d = stall_q;
      flush_d = flush_q;
      if (!mem_busy) begin
         wb_d.v    = mem_q.v;
         wb_d.dest = mem_q.dest;
         wb_d.rw   = mem_q.rw;
         mem_d     = ex_q;
         ex_d.v    = id_valid && !bubble;
         ex_d.dest = id_dest;
         ex_d.rw   = id_reg_write;
         ex_d.mr   = id_mem_read;
         exs_d.rs  = id_rs;
         exs_d.rt  = id_rt;
         exs_d.urs = id_uses_rs;
         exs_d.urt = id_uses_rt;
         if (ex_redirect) begin
            if (flush_q != CNT_MAX) flush_d = flush_q + CNT_W'(1);
         end else if (load_use) begin
            if (stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         exs_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         exs_q   <= exs_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   // EX operand selects: the younger MEM producer wins over WB; a MEM load never forwards.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (!reset && ex_q.v) begin
         if (exs_q.urs) begin
            if (slot_writes(mem_q, exs_q.rs)) fwd_a = mem_q.mr ? FWD_RF : FWD_MEM;
            else if (wb_writes(wb_q, exs_q.rs)) fwd_a = FWD_WB;
         end
         if (exs_q.urt) begin
            if (slot_writes(mem_q, exs_q.rt)) fwd_b = mem_q.mr ? FWD_RF : FWD_MEM;
            else if (wb_writes(wb_q, exs_q.rt)) fwd_b = FWD_WB;
         end
      end
   end

   assign id_bypass_a = !reset && id_valid && id_uses_rs && wb_writes(wb_q, id_rs);
   assign id_bypass_b = !reset && id_valid && id_uses_rt && wb_writes(wb_q, id_rt);

   assign stall_cnt = reset ? '0 : stall_q;
   assign flush_cnt = reset ? '0 : flush_q;

   assign mem_load_hit = ex_q.v && mem_q.mr &&
                         ((exs_q.urs && slot_writes(mem_q, exs_q.rs)) ||
                          (exs_q.urt && slot_writes(mem_q, exs_q.rt)));

   // The load-use stall must make a MEM-stage load feeding EX unreachable.
   a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (reset) !mem_load_hit);

endmodule
